// File: rtl/axi_if.sv
// AXI4 bundle shared by both sides of the slice; read and write halves have their own
// manager/subordinate modports so each direction can be connected independently.
interface axi_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned IW = 3,
    parameter int unsigned UW = 32
);
    logic [AW-1:0]   araddr;
    logic [1:0]      arburst;
    logic [2:0]      arsize;
    logic [7:0]      arlen;
    logic [UW-1:0]   aruser;
    logic [IW-1:0]   arid;
    logic            arlock;
    logic            arvalid;
    logic            arready;

    logic [AW-1:0]   awaddr;
    logic [1:0]      awburst;
    logic [2:0]      awsize;
    logic [7:0]      awlen;
    logic [UW-1:0]   awuser;
    logic [IW-1:0]   awid;
    logic            awlock;
    logic            awvalid;
    logic            awready;

    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic [IW-1:0]   rid;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [1:0]      bresp;
    logic [IW-1:0]   bid;
    logic            bvalid;
    logic            bready;

    modport r_mgr (
        output araddr, arburst, arsize, arlen, aruser, arid, arlock, arvalid,
        input  arready,
        input  rdata, rresp, rid, rlast, rvalid,
        output rready
    );

    modport r_sub (
        input  araddr, arburst, arsize, arlen, aruser, arid, arlock, arvalid,
        output arready,
        output rdata, rresp, rid, rlast, rvalid,
        input  rready
    );

    modport w_mgr (
        output awaddr, awburst, awsize, awlen, awuser, awid, awlock, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bid, bvalid,
        output bready
    );

    modport w_sub (
        input  awaddr, awburst, awsize, awlen, awuser, awid, awlock, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bid, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_slice.sv
// AXI4 register slice: each of the five channels is independently a wire (0),
// a 2-entry skid buffer (1) or a single half-rate register (2).
module axi_slice #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned IW      = 3,
    parameter int unsigned UW      = 32,
    parameter int unsigned AR_MODE = 1,
    parameter int unsigned AW_MODE = 1,
    parameter int unsigned W_MODE  = 1,
    parameter int unsigned R_MODE  = 1,
    parameter int unsigned B_MODE  = 1
) (
    input  logic   clk,
    input  logic   rst,
    axi_if.r_sub   s_r,
    axi_if.w_sub   s_w,
    axi_if.r_mgr   m_r,
    axi_if.w_mgr   m_w,
    output logic   idle
);

    localparam int unsigned ChAr = 0;
    localparam int unsigned ChAw = 1;
    localparam int unsigned ChW  = 2;
    localparam int unsigned ChR  = 3;
    localparam int unsigned ChB  = 4;
    localparam int unsigned NumCh = 5;

    localparam int unsigned AxW = AW + UW + IW + 14;
    localparam int unsigned WW  = DW + DW / 8 + 1;
    localparam int unsigned RW  = DW + IW + 3;
    localparam int unsigned BW  = IW + 2;

    function automatic int unsigned chan_width(int unsigned ch);
        case (ch)
            ChAr, ChAw: return AxW;
            ChW:        return WW;
            ChR:        return RW;
            default:    return BW;
        endcase
    endfunction

    function automatic int unsigned chan_mode(int unsigned ch);
        case (ch)
            ChAr:    return AR_MODE;
            ChAw:    return AW_MODE;
            ChW:     return W_MODE;
            ChR:     return R_MODE;
            default: return B_MODE;
        endcase
    endfunction

    logic [NumCh-1:0] ch_empty;

    assign idle = &ch_empty;

    for (genvar i = 0; i < NumCh; i++) begin : g_ch
        localparam int unsigned W    = chan_width(i);
        localparam int unsigned Mode = chan_mode(i);

        logic [W-1:0] in_data;
        logic [W-1:0] out_data;
        logic         in_valid;
        logic         in_ready;
        logic         out_valid;
        logic         out_ready;

        // Map each channel onto a generic producer/consumer pair; R and B run m->s.
        if (i == ChAr) begin : g_ar
            assign in_data     = {s_r.araddr, s_r.arburst, s_r.arsize, s_r.arlen,
                                  s_r.aruser, s_r.arid, s_r.arlock};
            assign in_valid    = s_r.arvalid;
            assign s_r.arready = in_ready;
            assign {m_r.araddr, m_r.arburst, m_r.arsize, m_r.arlen,
                    m_r.aruser, m_r.arid, m_r.arlock} = out_data;
            assign m_r.arvalid = out_valid;
            assign out_ready   = m_r.arready;
        end else if (i == ChAw) begin : g_aw
            assign in_data     = {s_w.awaddr, s_w.awburst, s_w.awsize, s_w.awlen,
                                  s_w.awuser, s_w.awid, s_w.awlock};
            assign in_valid    = s_w.awvalid;
            assign s_w.awready = in_ready;
            assign {m_w.awaddr, m_w.awburst, m_w.awsize, m_w.awlen,
                    m_w.awuser, m_w.awid, m_w.awlock} = out_data;
            assign m_w.awvalid = out_valid;
            assign out_ready   = m_w.awready;
        end else if (i == ChW) begin : g_w
            assign in_data    = {s_w.wdata, s_w.wstrb, s_w.wlast};
            assign in_valid   = s_w.wvalid;
            assign s_w.wready = in_ready;
            assign {m_w.wdata, m_w.wstrb, m_w.wlast} = out_data;
            assign m_w.wvalid = out_valid;
            assign out_ready  = m_w.wready;
        end else if (i == ChR) begin : g_r
            assign in_data    = {m_r.rdata, m_r.rresp, m_r.rid, m_r.rlast};
            assign in_valid   = m_r.rvalid;
            assign m_r.rready = in_ready;
            assign {s_r.rdata, s_r.rresp, s_r.rid, s_r.rlast} = out_data;
            assign s_r.rvalid = out_valid;
            assign out_ready  = s_r.rready;
        end else begin : g_b
            assign in_data    = {m_w.bresp, m_w.bid};
            assign in_valid   = m_w.bvalid;
            assign m_w.bready = in_ready;
            assign {s_w.bresp, s_w.bid} = out_data;
            assign s_w.bvalid = out_valid;
            assign out_ready  = s_w.bready;
        end

        if (Mode == 0) begin : g_bypass
            assign out_valid   = in_valid;
            assign in_ready    = out_ready;
            assign out_data    = in_data;
            assign ch_empty[i] = 1'b1;
        end else if (Mode <= 2) begin : g_buf
            // Light mode is the same buffer capped at one entry, which forbids push+pop.
            localparam logic [1:0] Cap = (Mode == 1) ? 2'd2 : 2'd1;

            logic [1:0]   cnt_q, cnt_d;
            logic         rdy_q, rdy_d;
            logic [W-1:0] main_q, main_d;
            logic [W-1:0] skid_q, skid_d;
            logic         push;
            logic         pop;

            assign push        = in_valid & rdy_q;
            assign pop         = out_valid & out_ready;
            assign out_valid   = (cnt_q != 2'd0);
            assign in_ready    = rdy_q;
            assign out_data    = main_q;
            assign ch_empty[i] = (cnt_q == 2'd0);

            always_comb begin
                cnt_d  = cnt_q;
                main_d = main_q;
                skid_d = skid_q;
                case ({push, pop})
                    2'b10: begin
                        if (cnt_q == 2'd0) begin
                            main_d = in_data;
                        end else begin
                            skid_d = in_data;
                        end
                        cnt_d = cnt_q + 2'd1;
                    end
                    2'b01: begin
                        main_d = skid_q;
                        cnt_d  = cnt_q - 2'd1;
                    end
                    // Only reachable at count 1 in full mode: replace main, count unchanged.
                    2'b11: main_d = in_data;
                    default: ;
                endcase
                rdy_d = (cnt_d < Cap);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q  <= 2'd0;
                    rdy_q  <= 1'b0;
                    main_q <= '0;
                    skid_q <= '0;
                end else begin
                    cnt_q  <= cnt_d;
                    rdy_q  <= rdy_d;
                    main_q <= main_d;
                    skid_q <= skid_d;
                end
            end
        end else begin : g_bad_mode
            $error("axi_slice: channel %0d has unsupported mode %0d", i, Mode);
        end
    end

endmodule

// File: tb/tb_axi_slice.sv
// Directed bench for axi_slice with AR/AW/W full, R light and B bypass; a single
// expectation queue holds beats pushed at input handshakes and popped at outputs.
module tb_axi_slice;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 4;
    localparam int unsigned UW = 8;

    logic clk;
    logic rst;
    logic idle;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] exp_q[$];

    axi_if #(.AW(AW), .DW(DW), .IW(IW), .UW(UW)) up ();
    axi_if #(.AW(AW), .DW(DW), .IW(IW), .UW(UW)) dn ();

    axi_slice #(
        .AW(AW), .DW(DW), .IW(IW), .UW(UW),
        .AR_MODE(1), .AW_MODE(1), .W_MODE(1), .R_MODE(2), .B_MODE(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .s_r (up),
        .s_w (up),
        .m_r (dn),
        .m_w (dn),
        .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(string tag, logic [63:0] obs);
        if (exp_q.size() == 0) chk({tag, "_queue"}, 64'(exp_q.size()), 64'd1);
        else chk(tag, obs, exp_q.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        up.araddr = '0; up.arburst = '0; up.arsize = '0; up.arlen = '0;
        up.aruser = '0; up.arid = '0; up.arlock = 1'b0; up.arvalid = 1'b0;
        up.awaddr = '0; up.awburst = '0; up.awsize = '0; up.awlen = '0;
        up.awuser = '0; up.awid = '0; up.awlock = 1'b0; up.awvalid = 1'b0;
        up.wdata = '0; up.wstrb = '0; up.wlast = 1'b0; up.wvalid = 1'b0;
        up.rready = 1'b0; up.bready = 1'b0;
        dn.arready = 1'b0; dn.awready = 1'b0; dn.wready = 1'b0;
        dn.rdata = '0; dn.rresp = '0; dn.rid = '0; dn.rlast = 1'b0; dn.rvalid = 1'b0;
        dn.bresp = '0; dn.bid = '0; dn.bvalid = 1'b0;
    endtask

    int k, n_out, first_acc, first_out, last_out, acc, acc2_cyc;

    initial begin
        rst = 1'b1;
        clear_inputs();
        #3;
        chk("rst_m_arvalid", 64'(dn.arvalid), 64'd0);
        chk("rst_m_awvalid", 64'(dn.awvalid), 64'd0);
        chk("rst_m_wvalid", 64'(dn.wvalid), 64'd0);
        chk("rst_s_rvalid", 64'(up.rvalid), 64'd0);
        chk("rst_s_arready", 64'(up.arready), 64'd0);
        chk("rst_s_awready", 64'(up.awready), 64'd0);
        chk("rst_s_wready", 64'(up.wready), 64'd0);
        chk("rst_m_rready", 64'(dn.rready), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rel_s_arready", 64'(up.arready), 64'd1);
        chk("rel_s_awready", 64'(up.awready), 64'd1);
        chk("rel_s_wready", 64'(up.wready), 64'd1);
        chk("rel_m_rready", 64'(dn.rready), 64'd1);

        // W: 16 back-to-back beats through the full buffer.
        dn.wready = 1'b1;
        k = 0; n_out = 0; first_acc = -1; first_out = -1; last_out = -1;
        for (int c = 0; c < 40 && n_out < 16; c++) begin
            up.wvalid = (k < 16);
            up.wdata  = 32'(k);
            up.wstrb  = 4'hF;
            up.wlast  = (k == 15);
            @(negedge clk);
            if (dn.wvalid) begin
                if (first_out < 0) begin
                    first_out = c;
                    chk("w_busy_idle", 64'(idle), 64'd0);
                end
                pop_chk("w_beat", 64'({dn.wlast, dn.wstrb, dn.wdata}));
                n_out++;
                last_out = c;
            end
            if (up.wvalid && up.wready) begin
                exp_q.push_back(64'({up.wlast, up.wstrb, up.wdata}));
                if (first_acc < 0) first_acc = c;
                k++;
            end
            tick();
        end
        up.wvalid = 1'b0;
        chk("w_count", 64'(n_out), 64'd16);
        chk("w_latency", 64'(first_out), 64'(first_acc + 1));
        chk("w_no_bubble", 64'(last_out - first_out), 64'd15);
        @(negedge clk);
        chk("w_idle_after", 64'(idle), 64'd1);
        tick();

        // AR: downstream stalled 6 cycles while 5 requests are offered.
        k = 0; n_out = 0; acc = 0; acc2_cyc = -1;
        for (int c = 0; c < 40 && n_out < 5; c++) begin
            up.arvalid = (k < 5);
            up.arid    = 4'(k);
            up.araddr  = 32'h100 + 32'(k);
            dn.arready = (c >= 6);
            @(negedge clk);
            if (dn.arvalid && dn.arready) begin
                pop_chk("ar_beat", 64'({dn.arid, dn.araddr}));
                n_out++;
            end
            if (up.arvalid && up.arready) begin
                exp_q.push_back(64'({up.arid, up.araddr}));
                acc++;
                k++;
                if (acc == 2) acc2_cyc = c;
            end
            if (acc2_cyc >= 0 && c == acc2_cyc + 1) chk("ar_ready_low", 64'(up.arready), 64'd0);
            if (c == 5) begin
                chk("ar_stall_accepts", 64'(acc), 64'd2);
                chk("ar_stall_ready", 64'(up.arready), 64'd0);
                chk("ar_hold_id", 64'(dn.arid), 64'd0);
            end
            tick();
        end
        up.arvalid = 1'b0;
        dn.arready = 1'b0;
        chk("ar_count", 64'(n_out), 64'd5);
        chk("ar_queue_empty", 64'(exp_q.size()), 64'd0);

        // R: light mode, continuous offer, half rate.
        up.rready = 1'b1;
        k = 0; n_out = 0; last_out = -1;
        for (int c = 0; c < 40 && n_out < 8; c++) begin
            dn.rvalid = (k < 8);
            dn.rdata  = 32'hA0 + 32'(k);
            dn.rid    = 4'(k);
            dn.rlast  = (k == 7);
            @(negedge clk);
            if (c < 16) chk("r_rready_alt", 64'(dn.rready), 64'(c % 2 == 0));
            if (up.rvalid) begin
                pop_chk("r_beat", 64'({up.rid, up.rlast, up.rdata}));
                n_out++;
                last_out = c;
            end
            if (dn.rvalid && dn.rready) begin
                exp_q.push_back(64'({dn.rid, dn.rlast, dn.rdata}));
                k++;
            end
            tick();
        end
        dn.rvalid = 1'b0;
        chk("r_count", 64'(n_out), 64'd8);
        chk("r_last_cycle", 64'(last_out), 64'd15);

        // B: bypass is purely combinational.
        dn.bvalid = 1'b1; dn.bid = 4'd5; dn.bresp = 2'b01; up.bready = 1'b0;
        #1;
        chk("b_valid", 64'(up.bvalid), 64'd1);
        chk("b_id", 64'(up.bid), 64'd5);
        chk("b_resp", 64'(up.bresp), 64'd1);
        chk("b_ready_lo", 64'(dn.bready), 64'd0);
        up.bready = 1'b1;
        #1;
        chk("b_ready_hi", 64'(dn.bready), 64'd1);
        up.bready = 1'b0;
        #1;
        chk("b_ready_lo2", 64'(dn.bready), 64'd0);
        dn.bvalid = 1'b0;
        #1;
        chk("b_valid_lo", 64'(up.bvalid), 64'd0);
        tick();

        // AW: fill both entries, then reset mid-burst.
        dn.awready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            up.awvalid = 1'b1;
            up.awid    = 4'(c + 1);
            up.awaddr  = 32'h300 + 32'(c);
            tick();
        end
        up.awvalid = 1'b0;
        chk("awrst_full_valid", 64'(dn.awvalid), 64'd1);
        chk("awrst_full_ready", 64'(up.awready), 64'd0);
        chk("awrst_busy_idle", 64'(idle), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("awrst_valid_drop", 64'(dn.awvalid), 64'd0);
        chk("awrst_idle", 64'(idle), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        dn.awready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) chk("awrst_ready_back", 64'(up.awready), 64'd1);
            @(negedge clk);
            chk("awrst_no_stale", 64'(dn.awvalid), 64'd0);
        end
        tick();

        // AW: simultaneous push/pop at count 1 for 10 cycles.
        k = 0; n_out = 0;
        for (int c = 0; c < 30 && n_out < 10; c++) begin
            up.awvalid = (k < 10);
            up.awid    = 4'(k);
            up.awaddr  = 32'h2000 + 32'(k * 4);
            @(negedge clk);
            if (c >= 1 && c <= 10) chk("aw_steady_valid", 64'(dn.awvalid), 64'd1);
            if (c <= 9) chk("aw_steady_ready", 64'(up.awready), 64'd1);
            if (dn.awvalid && dn.awready) begin
                pop_chk("aw_beat", 64'({dn.awid, dn.awaddr}));
                n_out++;
            end
            if (up.awvalid && up.awready) begin
                exp_q.push_back(64'({up.awid, up.awaddr}));
                k++;
            end
            tick();
        end
        up.awvalid = 1'b0;
        chk("aw_count", 64'(n_out), 64'd10);
        chk("aw_queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk("aw_idle_after", 64'(idle), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
